// File: rtl/nand_axil_regfile.sv
// AXI4-Lite slave register file with byte strobes, read-only status slots,
// SLVERR on out-of-range indices and a per-register write doorbell pulse.
module nand_axil_regfile #(
  parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS           = 8,
  parameter int unsigned         C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0] RO_MASK            = 'h80
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(SW);
  localparam int unsigned IDXW     = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned RIW      = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                          ready_q;
  logic                          aw_full_q, aw_full_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                          w_full_q, w_full_d;
  logic [DW-1:0]                 w_data_q, w_data_d;
  logic [SW-1:0]                 w_strb_q, w_strb_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          rvalid_q, rvalid_d;
  logic [DW-1:0]                 rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [NUM_REGS-1:0]           pulse_q, pulse_d;
  logic [DW-1:0]                 regs_q [NUM_REGS];
  logic [DW-1:0]                 regs_d [NUM_REGS];
  logic [DW-1:0]                 status_arr [NUM_REGS];

  logic                          aw_hs, w_hs, ar_hs, b_free, commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [DW-1:0]                 wr_data;
  logic [SW-1:0]                 wr_strb;
  logic [IDXW-1:0]               wr_idx, rd_idx;
  logic [31:0]                   wr_idx32, rd_idx32;
  logic [RIW-1:0]                wr_ridx, rd_ridx;
  logic                          wr_in_range, rd_in_range;
  logic                          unused_bits;

  // Readies stay low until the first edge after reset release.
  assign S_AXI_AWREADY = ready_q && !aw_full_q;
  assign S_AXI_WREADY  = ready_q && !w_full_q;
  assign S_AXI_ARREADY = ready_q && (!rvalid_q || S_AXI_RREADY);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = pulse_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign b_free = !bvalid_q || S_AXI_BREADY;
  assign commit = (aw_full_q || aw_hs) && (w_full_q || w_hs) && b_free;

  // A live handshake can commit directly, bypassing the empty buffer.
  assign wr_addr = aw_full_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;

  assign wr_idx      = wr_addr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_idx32    = 32'(wr_idx);
  assign wr_in_range = wr_idx32 < NUM_REGS;
  assign wr_ridx     = wr_idx[RIW-1:0];

  assign rd_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx32    = 32'(rd_idx);
  assign rd_in_range = rd_idx32 < NUM_REGS;
  assign rd_ridx     = rd_idx[RIW-1:0];

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         wr_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slice
    assign status_arr[g]         = status_in[g*DW +: DW];
    assign reg_out[g*DW +: DW]   = RO_MASK[g] ? '0 : regs_q[g];
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_range && !RO_MASK[wr_ridx]) begin
        pulse_d[wr_ridx] = 1'b1;
        for (int unsigned b = 0; b < SW; b++) begin
          if (wr_strb[b]) regs_d[wr_ridx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_addr_d = S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = S_AXI_WDATA;
        w_strb_d = S_AXI_WSTRB;
      end
      if (S_AXI_BREADY) bvalid_d = 1'b0;
    end
  end

  // Reads sample regs_q, so a same-edge commit is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (!rd_in_range) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (RO_MASK[rd_ridx]) begin
        rdata_d = status_arr[rd_ridx];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = regs_q[rd_ridx];
        rresp_d = RESP_OKAY;
      end
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_q   <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      pulse_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ready_q   <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_nand_axil_regfile.sv
// Directed bench for nand_axil_regfile: vector table of single AXI-Lite
// transactions plus hand-written back-pressure, same-edge and reset sequences.
module tb_nand_axil_regfile;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 6;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [AW-1:0]     S_AXI_AWADDR = '0;
  logic [2:0]        S_AXI_AWPROT = '0;
  logic              S_AXI_AWVALID = 1'b0;
  logic              S_AXI_AWREADY;
  logic [DW-1:0]     S_AXI_WDATA = '0;
  logic [DW/8-1:0]   S_AXI_WSTRB = '0;
  logic              S_AXI_WVALID = 1'b0;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY = 1'b0;
  logic [AW-1:0]     S_AXI_ARADDR = '0;
  logic [2:0]        S_AXI_ARPROT = '0;
  logic              S_AXI_ARVALID = 1'b0;
  logic              S_AXI_ARREADY;
  logic [DW-1:0]     S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY = 1'b0;
  logic [NR*DW-1:0]  reg_out;
  logic [NR*DW-1:0]  status_in = '0;
  logic [NR-1:0]     wr_pulse;

  nand_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(DW),
    .NUM_REGS(NR),
    .C_S_AXI_ADDR_WIDTH(AW),
    .RO_MASK(8'h80)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    logic [NR-1:0] pulse;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All stimulus lives at 1 time unit after a rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic vec_t wv(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [3:0] s, input logic [1:0] r, input logic [NR-1:0] p);
    vec_t v;
    v.is_rd = 1'b0; v.addr = a; v.wdata = d; v.strb = s; v.resp = r; v.rdata = '0; v.pulse = p;
    return v;
  endfunction

  function automatic vec_t rv(input logic [AW-1:0] a, input logic [1:0] r, input logic [DW-1:0] d);
    vec_t v;
    v.is_rd = 1'b1; v.addr = a; v.wdata = '0; v.strb = '0; v.resp = r; v.rdata = d; v.pulse = '0;
    return v;
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [NR-1:0] pulse,
                           output logic [NR-1:0] pulse_after, output int lat, output bit ok);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit hs_aw, hs_w;
    int n = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    ok = 1'b0; resp = 2'b11; pulse = '1; pulse_after = '1; lat = -1;
    while (!(aw_done && w_done) && n < 20) begin
      #8;
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      n++;
      if (hs_aw) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_done  = 1'b1; S_AXI_WVALID  = 1'b0; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    lat = 0;
    while (!S_AXI_BVALID && n < 20) begin tick(); n++; lat++; end
    if (S_AXI_BVALID) begin
      ok = 1'b1; resp = S_AXI_BRESP; pulse = wr_pulse;
    end
    tick();
    pulse_after = wr_pulse;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [1:0] resp, output bit ok);
    bit done = 1'b0;
    bit hs;
    int n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    ok = 1'b0; d = '1; resp = 2'b11;
    while (!done && n < 20) begin
      #8;
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      n++;
      if (hs) begin done = 1'b1; S_AXI_ARVALID = 1'b0; end
    end
    S_AXI_ARVALID = 1'b0;
    if (done && S_AXI_RVALID) begin
      ok = 1'b1; d = S_AXI_RDATA; resp = S_AXI_RRESP;
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    resp;
    logic [NR-1:0] pls, pls_after;
    logic [DW-1:0] rd;
    int            lat;
    int            p2_cnt;
    bit            ok;
    logic [DW-1:0] exp_regs [NR];

    status_in[0*DW +: DW] = 32'h12345678;
    status_in[1*DW +: DW] = 32'hCAFEF00D;
    status_in[7*DW +: DW] = 32'hDEADBEEF;

    vecs.push_back(wv(6'h00, 32'h1, 4'hF, 2'b00, 8'h01));
    vecs.push_back(wv(6'h04, 32'h2, 4'hF, 2'b00, 8'h02));
    vecs.push_back(wv(6'h08, 32'h3, 4'hF, 2'b00, 8'h04));
    vecs.push_back(wv(6'h0C, 32'h4, 4'hF, 2'b00, 8'h08));
    vecs.push_back(rv(6'h00, 2'b00, 32'h1));
    vecs.push_back(rv(6'h04, 2'b00, 32'h2));
    vecs.push_back(rv(6'h08, 2'b00, 32'h3));
    vecs.push_back(rv(6'h0C, 2'b00, 32'h4));
    vecs.push_back(wv(6'h04, 32'hAABBCCDD, 4'hF, 2'b00, 8'h02));
    vecs.push_back(wv(6'h04, 32'h11223344, 4'h5, 2'b00, 8'h02));
    vecs.push_back(rv(6'h04, 2'b00, 32'hAA22CC44));
    vecs.push_back(rv(6'h1C, 2'b00, 32'hDEADBEEF));
    vecs.push_back(wv(6'h1C, 32'h0, 4'hF, 2'b00, 8'h00));
    vecs.push_back(rv(6'h1C, 2'b00, 32'hDEADBEEF));
    vecs.push_back(wv(6'h20, 32'hFFFFFFFF, 4'hF, 2'b10, 8'h00));
    vecs.push_back(rv(6'h20, 2'b10, 32'h0));
    vecs.push_back(wv(6'h3C, 32'h12, 4'hF, 2'b10, 8'h00));
    vecs.push_back(rv(6'h3E, 2'b10, 32'h0));
    vecs.push_back(wv(6'h08, 32'hFFFFFFFF, 4'h0, 2'b00, 8'h04));
    vecs.push_back(rv(6'h0B, 2'b00, 32'h3));
    vecs.push_back(rv(6'h00, 2'b00, 32'h1));
    vecs.push_back(wv(6'h14, 32'h0000BEEF, 4'h3, 2'b00, 8'h20));
    vecs.push_back(rv(6'h14, 2'b00, 32'h0000BEEF));
    vecs.push_back(rv(6'h1E, 2'b00, 32'hDEADBEEF));

    // Reset state, including across a clock edge while held.
    #12;
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);
    chk("rst_rresp", S_AXI_RRESP, 0);
    chk("rst_pulse", wr_pulse, 0);
    for (int k = 0; k < NR; k++) chk($sformatf("rst_reg%0d", k), reg_out[k*DW +: DW], 0);
    ARESETN = 1'b1;
    tick();
    chk("post_rst_awready", S_AXI_AWREADY, 1);
    chk("post_rst_wready", S_AXI_WREADY, 1);
    chk("post_rst_arready", S_AXI_ARREADY, 1);

    foreach (vecs[i]) begin
      if (vecs[i].is_rd) begin
        axi_read(vecs[i].addr, rd, resp, ok);
        chk($sformatf("v%0d_r_done", i), ok, 1);
        chk($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
        chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      end else begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp, pls, pls_after, lat, ok);
        chk($sformatf("v%0d_w_done", i), ok, 1);
        chk($sformatf("v%0d_b_latency", i), lat, 0);
        chk($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
        chk($sformatf("v%0d_pulse", i), pls, vecs[i].pulse);
        chk($sformatf("v%0d_pulse_end", i), pls_after, 0);
      end
    end

    exp_regs = '{32'h1, 32'hAA22CC44, 32'h3, 32'h4, 32'h0, 32'h0000BEEF, 32'h0, 32'h0};
    for (int k = 0; k < NR; k++) chk($sformatf("regout%0d", k), reg_out[k*DW +: DW], exp_regs[k]);

    // W ahead of AW with B stalled; a second write waits in the buffers.
    p2_cnt = 0;
    S_AXI_BREADY = 1'b0;
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    chk("bp_wready_full", S_AXI_WREADY, 0);
    chk("bp_no_early_b", S_AXI_BVALID, 0);
    tick();
    tick();
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("bp_bvalid_rise", S_AXI_BVALID, 1);
    chk("bp_bresp", S_AXI_BRESP, 2'b00);
    chk("bp_pulse2", wr_pulse, 8'h04);
    chk("bp_reg2_new", reg_out[2*DW +: DW], 32'h55);
    p2_cnt += int'(wr_pulse[2]);
    S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = 32'h66; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    p2_cnt += int'(wr_pulse[2]);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("bp_awready_low", S_AXI_AWREADY, 0);
    chk("bp_wready_low", S_AXI_WREADY, 0);
    chk("bp_pulse_gone", wr_pulse, 0);
    chk("bp_reg3_held", reg_out[3*DW +: DW], 32'h4);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_bvalid_hold%0d", c), S_AXI_BVALID, 1);
      tick();
      p2_cnt += int'(wr_pulse[2]);
    end
    chk("bp_reg3_still", reg_out[3*DW +: DW], 32'h4);
    S_AXI_BREADY = 1'b1;
    tick();
    p2_cnt += int'(wr_pulse[2]);
    chk("bp_b2_bvalid", S_AXI_BVALID, 1);
    chk("bp_b2_pulse3", wr_pulse, 8'h08);
    chk("bp_reg3_new", reg_out[3*DW +: DW], 32'h66);
    tick();
    p2_cnt += int'(wr_pulse[2]);
    chk("bp_b_done", S_AXI_BVALID, 0);
    chk("bp_pulse_end", wr_pulse, 0);
    chk("bp_reg2_once", p2_cnt, 1);
    chk("bp_reg2_final", reg_out[2*DW +: DW], 32'h55);

    // Read and write commit to reg0 on the same edge.
    axi_write(6'h00, 32'h5, 4'hF, resp, pls, pls_after, lat, ok);
    chk("se_pre_done", ok, 1);
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("se_rvalid", S_AXI_RVALID, 1);
    chk("se_rdata_old", S_AXI_RDATA, 32'h5);
    chk("se_bvalid", S_AXI_BVALID, 1);
    tick();
    axi_read(6'h00, rd, resp, ok);
    chk("se_read2_done", ok, 1);
    chk("se_rdata_new", rd, 32'h9);

    // Reset asserted while a write response is pending.
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h77; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("mr_bvalid_pre", S_AXI_BVALID, 1);
    chk("mr_reg1_pre", reg_out[1*DW +: DW], 32'h77);
    ARESETN = 1'b0;
    #2;
    chk("mr_bvalid", S_AXI_BVALID, 0);
    chk("mr_awready", S_AXI_AWREADY, 0);
    chk("mr_arready", S_AXI_ARREADY, 0);
    for (int k = 0; k < NR; k++) chk($sformatf("mr_reg%0d", k), reg_out[k*DW +: DW], 0);
    ARESETN = 1'b1;
    S_AXI_BREADY = 1'b1;
    tick();
    chk("mr_awready_back", S_AXI_AWREADY, 1);
    chk("mr_no_resp", S_AXI_BVALID, 0);
    axi_read(6'h04, rd, resp, ok);
    chk("mr_read_done", ok, 1);
    chk("mr_reg1_zero", rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nand_axil_regfile.md
Name: nand_axil_regfile

Overview:
Parametrised AXI4-Lite slave register file, the successor to the fixed 4x32-bit register bank in the NAND flash controller IP. It provides NUM_REGS registers of C_S_AXI_DATA_WIDTH bits with byte strobes. Any register can be made read-only, so it returns a live status input instead. Out-of-range accesses get SLVERR, and each write raises a per-register one-cycle pulse that drives command doorbells in the NAND sequencer.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
NUM_REGS, 8, register count; power of two, at least 4.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must be at least log2(NUM_REGS)+log2(C_S_AXI_DATA_WIDTH/8).
RO_MASK, 0x80, NUM_REGS bits; bit i=1 makes register i read-only (status).

Ports:
ACLK  in  1  clock; all logic rising-edge.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read response.
reg_out  out  NUM_REGS*C_S_AXI_DATA_WIDTH  flattened RW register contents; register i sits at slice i.
status_in  in  NUM_REGS*C_S_AXI_DATA_WIDTH  status values; slice i is used only where RO_MASK[i]=1.
wr_pulse  out  NUM_REGS  one-cycle strobe per register on each committed write.

Behaviour:
- Reset (ARESETN low, asynchronous) clears:
  - all registers and the AW/W holding buffers;
  - BVALID, RVALID, RDATA, BRESP, RRESP and wr_pulse to 0;
  - AWREADY, WREADY and ARREADY to 0 while reset is asserted.
- Readies go high on the first edge after reset is released.
- A transaction in flight when reset asserts is dropped and gets no response.
- Address decode:
  - index = addr[C_S_AXI_ADDR_WIDTH-1 : log2(C_S_AXI_DATA_WIDTH/8)]; low byte-offset bits are ignored.
  - index >= NUM_REGS means out of range.
- Write path:
  - AW and W are accepted independently in any order, each into a one-entry buffer. AWREADY = !aw_buf_full and WREADY = !w_buf_full.
  - Commit happens at the rising edge where an address and data are both available (from the buffer or a handshake in the same cycle) and the B channel is free (!BVALID, or BVALID&&BREADY).
  - At commit: both buffers are released, BVALID=1 from the next cycle, and BRESP is fixed for that response.
  - Minimum latency: AW and W handshake together in cycle 0, so BVALID=1 in cycle 1.
  - If the B channel is busy, incoming AW/W wait in the buffers and further AW/W are back-pressured.
  - In-range RW register: bytes with WSTRB[b]=1 are updated, other bytes keep their value. wr_pulse[index]=1 for exactly the cycle in which BVALID first rises. The pulse fires even when WSTRB=0. BRESP=OKAY.
  - In-range RO register: no state change, no pulse, BRESP=OKAY.
  - Out of range: no state change, no pulse, BRESP=SLVERR.
- Read path:
  - ARREADY = !RVALID || RREADY, so back-to-back reads run at full rate.
  - On an AR handshake at edge t: RVALID=1 after t, and RDATA/RRESP are registered at t.
  - RW register: RDATA = register value before any write committing at the same edge t.
  - RO register: RDATA = status_in slice sampled at edge t.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - RDATA and RRESP hold stable while RVALID && !RREADY.
- Read and write channels are fully concurrent; one cycle can carry a write commit and a read handshake to the same register.
- reg_out reflects the register state combinationally from the flops, i.e. new values are visible the cycle after commit. The reg_out slice for an RO index is 0.

Test Plan:
- Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> OKAY each time; RDATA 1,2,3,4; wr_pulse[0..3] each high exactly one cycle, coinciding with BVALID rising.
- Write 0xAABBCCDD to reg1 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5 -> reg1 reads 0xAA22CC44.
- W presented 3 cycles before AW to reg2, with BREADY held low 4 cycles -> second AW/W back-pressured; BVALID held; register updated exactly once.
- Read reg7 (RO) with status_in slice 7 = 0xDEADBEEF; write 0 to reg7 -> read returns 0xDEADBEEF, OKAY; no wr_pulse[7].
- Access 0x20 (index 8) -> BRESP=10 and RRESP=10, RDATA=0, no register change.
- Same-edge AR and write commit to reg0 (old 5, new 9) -> RDATA=5; a following read returns 9. Then assert ARESETN low mid-write -> all registers 0, BVALID=0.
